// File: rtl/cp2_tt_pkg.sv
// Shared encodings, default widths and reset constants for the CP2 time-trigger unit.
package cp2_tt_pkg;

    localparam int TT_TIME_W = 64;
    localparam int TT_DATA_W = 32;

    typedef enum logic [1:0] {
        TT_KIND_TLO = 2'd0,
        TT_KIND_THI = 2'd1,
        TT_KIND_PER = 2'd2,
        TT_KIND_PH  = 2'd3
    } tt_kind_e;

    localparam logic [TT_TIME_W-1:0] TT_TIME_RST = '0;
    localparam logic [TT_DATA_W-1:0] TT_DATA_RST = '0;
    localparam logic                 TT_BIT_RST  = 1'b0;

endpackage

// File: rtl/cp2_tt_prio_enc.sv
// Lowest-index-first priority encoder; o_idx is 0 when nothing is requested.
module cp2_tt_prio_enc #(
    parameter int NUM_CH = 8,
    parameter int CH_AW  = 3
) (
    input  logic [NUM_CH-1:0] i_req,
    output logic              o_valid,
    output logic [CH_AW-1:0]  o_idx
);

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = CH_AW'(i);
        end
    end

endmodule

// File: rtl/cp2_tt_timer_unit.sv
// CP2 global time base with periodic / one-shot compare channels, pending and
// overrun tracking, a top-channel encoder and an empty->non-empty exception pulse.
module cp2_tt_timer_unit
    import cp2_tt_pkg::*;
#(
    parameter int TIME_W = TT_TIME_W,
    parameter int DATA_W = TT_DATA_W,
    parameter int NUM_CH = 8,
    parameter int CH_AW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_kind,
    input  logic [CH_AW-1:0]  wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              en_we,
    input  logic [CH_AW-1:0]  en_ch,
    input  logic              en_val,
    input  logic              rd_en,
    input  logic [1:0]        rd_kind,
    input  logic [CH_AW-1:0]  rd_ch,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              ack_en,
    input  logic [CH_AW-1:0]  ack_ch,
    input  logic              ovr_clr,
    output logic [TIME_W-1:0] g_time,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overrun,
    output logic              top_valid,
    output logic [CH_AW-1:0]  top_ch,
    output logic              exc
);

    localparam int HI_W = TIME_W - DATA_W;

    logic [TIME_W-1:0] r_time;
    logic [HI_W-1:0]   r_shadow;
    logic [DATA_W-1:0] r_per [NUM_CH];
    logic [DATA_W-1:0] r_nf  [NUM_CH];
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_pend_prev;
    logic [NUM_CH-1:0] r_ovr;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_exc;

    logic [DATA_W-1:0] w_per_nxt [NUM_CH];
    logic [DATA_W-1:0] w_nf_nxt  [NUM_CH];
    logic [NUM_CH-1:0] w_fire;
    logic [NUM_CH-1:0] w_en_nxt;
    logic [NUM_CH-1:0] w_pend_nxt;
    logic [NUM_CH-1:0] w_ovr_nxt;
    logic [TIME_W-1:0] w_time_nxt;
    logic [DATA_W-1:0] w_rd_val;
    logic              w_wr_tlo;
    logic              w_wr_thi;
    logic              w_top_valid;
    logic [CH_AW-1:0]  w_top_ch;

    assign w_wr_tlo = wr_en && (wr_kind == TT_KIND_TLO);
    assign w_wr_thi = wr_en && (wr_kind == TT_KIND_THI);

    // A half-write replaces the increment for that cycle.
    always_comb begin
        w_time_nxt = r_time + TIME_W'(1);
        if (w_wr_tlo) begin
            w_time_nxt = {r_time[TIME_W-1:DATA_W], wr_data};
        end else if (w_wr_thi) begin
            w_time_nxt = {wr_data[HI_W-1:0], r_time[DATA_W-1:0]};
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_sel_wr;
        logic w_ph_wr;
        logic w_sel_en;
        logic w_sel_ack;
        logic w_one_shot;

        // Out-of-range indices never match any generated channel.
        assign w_sel_wr   = wr_en && (wr_ch == CH_AW'(c));
        assign w_ph_wr    = w_sel_wr && (wr_kind == TT_KIND_PH);
        assign w_sel_en   = en_we && (en_ch == CH_AW'(c));
        assign w_sel_ack  = ack_en && (ack_ch == CH_AW'(c));
        assign w_one_shot = (r_per[c] == '0);

        assign w_fire[c] = r_en[c] && (r_time[DATA_W-1:0] == r_nf[c]) && !w_ph_wr;

        assign w_per_nxt[c] = (w_sel_wr && (wr_kind == TT_KIND_PER)) ? wr_data : r_per[c];

        assign w_nf_nxt[c] = w_ph_wr                     ? wr_data :
                             (w_fire[c] && !w_one_shot) ? r_nf[c] + r_per[c] :
                                                          r_nf[c];

        // An explicit enable write overrides the one-shot self-disable.
        assign w_en_nxt[c] = w_sel_en                  ? en_val :
                             (w_fire[c] && w_one_shot) ? 1'b0 :
                                                         r_en[c];

        assign w_pend_nxt[c] = w_fire[c] || (r_pend[c] && !w_sel_ack);
        assign w_ovr_nxt[c]  = (w_fire[c] && r_pend[c] && !w_sel_ack) || (r_ovr[c] && !ovr_clr);
    end

    always_comb begin
        w_rd_val = '0;
        case (rd_kind)
            TT_KIND_TLO: w_rd_val = r_time[DATA_W-1:0];
            TT_KIND_THI: w_rd_val = DATA_W'(r_shadow);
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (rd_ch == CH_AW'(c)) begin
                        w_rd_val = (rd_kind == TT_KIND_PER) ? r_per[c] : r_nf[c];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_time      <= TIME_W'(TT_TIME_RST);
            r_shadow    <= HI_W'(TT_TIME_RST);
            // NOTE: the channel arrays are reset too, since software may read them before writing.
            for (int c = 0; c < NUM_CH; c++) begin
                r_per[c] <= DATA_W'(TT_DATA_RST);
                r_nf[c]  <= DATA_W'(TT_DATA_RST);
            end
            r_en        <= {NUM_CH{TT_BIT_RST}};
            r_pend      <= {NUM_CH{TT_BIT_RST}};
            r_pend_prev <= {NUM_CH{TT_BIT_RST}};
            r_ovr       <= {NUM_CH{TT_BIT_RST}};
            r_rd_valid  <= TT_BIT_RST;
            r_rd_data   <= DATA_W'(TT_DATA_RST);
            r_exc       <= TT_BIT_RST;
        end else begin
            r_time <= w_time_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                r_per[c] <= w_per_nxt[c];
                r_nf[c]  <= w_nf_nxt[c];
            end
            r_en        <= w_en_nxt;
            r_pend      <= w_pend_nxt;
            r_ovr       <= w_ovr_nxt;
            r_pend_prev <= r_pend;
            r_exc       <= (|r_pend) && !(|r_pend_prev);
            r_rd_valid  <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_val;
            end
            // Low-half read latches the high half so a later high read is coherent.
            if (rd_en && (rd_kind == TT_KIND_TLO)) begin
                r_shadow <= r_time[TIME_W-1:DATA_W];
            end
        end
    end

    cp2_tt_prio_enc #(
        .NUM_CH (NUM_CH),
        .CH_AW  (CH_AW)
    ) u_prio_enc (
        .i_req   (r_pend),
        .o_valid (w_top_valid),
        .o_idx   (w_top_ch)
    );

    assign g_time    = r_time;
    assign pending   = r_pend;
    assign overrun   = r_ovr;
    assign top_valid = w_top_valid;
    assign top_ch    = w_top_ch;
    assign exc       = r_exc;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_cp2_tt_timer_unit.sv
// Scoreboard bench for cp2_tt_timer_unit: directed scenarios followed by random traffic,
// each cycle checked against a behavioural model of the time/trigger rules.
module tb_cp2_tt_timer_unit;

    localparam int TW  = 64;
    localparam int DW  = 32;
    localparam int NCH = 6;
    localparam int AW  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [1:0]     wr_kind;
    logic [AW-1:0]  wr_ch;
    logic [DW-1:0]  wr_data;
    logic           en_we;
    logic [AW-1:0]  en_ch;
    logic           en_val;
    logic           rd_en;
    logic [1:0]     rd_kind;
    logic [AW-1:0]  rd_ch;
    logic           rd_valid;
    logic [DW-1:0]  rd_data;
    logic           ack_en;
    logic [AW-1:0]  ack_ch;
    logic           ovr_clr;
    logic [TW-1:0]  g_time;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] overrun;
    logic           top_valid;
    logic [AW-1:0]  top_ch;
    logic           exc;

    always #5 clk = ~clk;

    cp2_tt_timer_unit #(
        .TIME_W (TW),
        .DATA_W (DW),
        .NUM_CH (NCH),
        .CH_AW  (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_kind   (wr_kind),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .en_we     (en_we),
        .en_ch     (en_ch),
        .en_val    (en_val),
        .rd_en     (rd_en),
        .rd_kind   (rd_kind),
        .rd_ch     (rd_ch),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .ack_en    (ack_en),
        .ack_ch    (ack_ch),
        .ovr_clr   (ovr_clr),
        .g_time    (g_time),
        .pending   (pending),
        .overrun   (overrun),
        .top_valid (top_valid),
        .top_ch    (top_ch),
        .exc       (exc)
    );

    typedef struct packed {
        logic [TW-1:0]  t;
        logic [NCH-1:0] pend;
        logic [NCH-1:0] ovr;
        logic           tv;
        logic [AW-1:0]  tc;
        logic           exc;
        logic           rv;
    } exp_t;

    exp_t          st_q[$];
    logic [DW-1:0] rd_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            mon_en   = 1'b0;

    // Reference model state
    logic [TW-1:0]    m_time;
    logic [TW-DW-1:0] m_shadow;
    logic [DW-1:0]    m_per [NCH];
    logic [DW-1:0]    m_nf  [NCH];
    logic [NCH-1:0]   m_en;
    logic [NCH-1:0]   m_pend;
    logic [NCH-1:0]   m_pend_prev;
    logic [NCH-1:0]   m_ovr;
    logic             m_exc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        exp_t           e;
        logic [NCH-1:0] p_old;
        logic [DW-1:0]  rv;
        bit             fire;
        bit             ph_wr;
        bit             sel_ack;
        if (rst) begin
            m_time      = '0;
            m_shadow    = '0;
            m_en        = '0;
            m_pend      = '0;
            m_pend_prev = '0;
            m_ovr       = '0;
            m_exc       = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                m_per[c] = '0;
                m_nf[c]  = '0;
            end
            e.rv = 1'b0;
        end else begin
            p_old = m_pend;
            e.rv  = rd_en;
            if (rd_en) begin
                rv = '0;
                case (rd_kind)
                    2'd0:    rv = m_time[DW-1:0];
                    2'd1:    rv = DW'(m_shadow);
                    2'd2:    if (int'(rd_ch) < NCH) rv = m_per[int'(rd_ch)];
                    default: if (int'(rd_ch) < NCH) rv = m_nf[int'(rd_ch)];
                endcase
                rd_q.push_back(rv);
                if (rd_kind == 2'd0) m_shadow = m_time[TW-1:DW];
            end
            for (int c = 0; c < NCH; c++) begin
                ph_wr   = wr_en && (wr_kind == 2'd3) && (int'(wr_ch) == c);
                sel_ack = ack_en && (int'(ack_ch) == c);
                fire    = m_en[c] && (m_time[DW-1:0] == m_nf[c]) && !ph_wr;
                if (ovr_clr) m_ovr[c] = 1'b0;
                if (fire) begin
                    if (p_old[c] && !sel_ack) m_ovr[c] = 1'b1;
                    m_pend[c] = 1'b1;
                    if (m_per[c] == '0) m_en[c] = 1'b0;
                    else                m_nf[c] = m_nf[c] + m_per[c];
                end else if (sel_ack) begin
                    m_pend[c] = 1'b0;
                end
                if (ph_wr) m_nf[c] = wr_data;
                if (wr_en && (wr_kind == 2'd2) && (int'(wr_ch) == c)) m_per[c] = wr_data;
                if (en_we && (int'(en_ch) == c)) m_en[c] = en_val;
            end
            if (wr_en && (wr_kind == 2'd0))      m_time[DW-1:0]  = wr_data;
            else if (wr_en && (wr_kind == 2'd1)) m_time[TW-1:DW] = wr_data[TW-DW-1:0];
            else                                 m_time          = m_time + 64'd1;
            m_exc       = (p_old != '0) && (m_pend_prev == '0);
            m_pend_prev = p_old;
        end
        e.t   = m_time;
        e.pend = m_pend;
        e.ovr = m_ovr;
        e.exc = m_exc;
        e.tv  = 1'b0;
        e.tc  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (m_pend[c] && !e.tv) begin
                e.tv = 1'b1;
                e.tc = AW'(c);
            end
        end
        st_q.push_back(e);
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge with strobes cleared.
    task automatic step();
        model_step();
        mon_en = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        en_we   = 1'b0;
        rd_en   = 1'b0;
        ack_en  = 1'b0;
        ovr_clr = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_wr(input logic [1:0] k, input int ch, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_kind = k; wr_ch = AW'(ch); wr_data = d;
        step();
    endtask

    task automatic do_en(input int ch, input logic v);
        en_we = 1'b1; en_ch = AW'(ch); en_val = v;
        step();
    endtask

    task automatic do_ack(input int ch);
        ack_en = 1'b1; ack_ch = AW'(ch);
        step();
    endtask

    task automatic do_rd(input logic [1:0] k, input int ch);
        rd_en = 1'b1; rd_kind = k; rd_ch = AW'(ch);
        step();
    endtask

    // Idle until the current cycle's low time equals tg (bounded).
    task automatic run_until_lo(input logic [DW-1:0] tg);
        int n = 0;
        while ((m_time[DW-1:0] != tg) && (n < 300)) begin
            step();
            n++;
        end
        check("reach_time", 64'(g_time[DW-1:0]), 64'(tg));
    endtask

    task automatic rand_cycle();
        int r;
        rst     = ($urandom_range(0, 399) == 0);
        wr_en   = ($urandom_range(0, 2) == 0);
        r       = $urandom_range(0, 9);
        wr_kind = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r < 5) ? 2'd2 : 2'd3;
        wr_ch   = AW'($urandom_range(0, 7));
        case (wr_kind)
            2'd0: wr_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                        : m_time[DW-1:0] - 32'($urandom_range(0, 20));
            2'd1: wr_data = 32'($urandom_range(0, 3));
            2'd2: wr_data = 32'($urandom_range(0, 6));
            default: wr_data = m_time[DW-1:0] + 32'($urandom_range(1, 12));
        endcase
        en_we   = ($urandom_range(0, 3) == 0);
        en_ch   = AW'($urandom_range(0, 7));
        en_val  = ($urandom_range(0, 3) != 0);
        rd_en   = ($urandom_range(0, 2) == 0);
        rd_kind = 2'($urandom_range(0, 3));
        rd_ch   = AW'($urandom_range(0, 7));
        ack_en  = ($urandom_range(0, 2) == 0);
        ack_ch  = AW'($urandom_range(0, 7));
        ovr_clr = ($urandom_range(0, 15) == 0);
        step();
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (st_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: no expected state at %0t", $time);
                end else begin
                    e = st_q.pop_front();
                    check("g_time",    g_time,            e.t);
                    check("pending",   64'(pending),      64'(e.pend));
                    check("overrun",   64'(overrun),      64'(e.ovr));
                    check("top_valid", 64'(top_valid),    64'(e.tv));
                    check("top_ch",    64'(top_ch),       64'(e.tc));
                    check("exc",       64'(exc),          64'(e.exc));
                    check("rd_valid",  64'(rd_valid),     64'(e.rv));
                    if (e.rv) begin
                        if (rd_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL rd_queue_empty: rd_data 0x%0h with no expectation", rd_data);
                        end else begin
                            check("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [DW-1:0] tg;
        rst = 1'b1; wr_en = 1'b0; wr_kind = '0; wr_ch = '0; wr_data = '0;
        en_we = 1'b0; en_ch = '0; en_val = 1'b0; rd_en = 1'b0; rd_kind = '0; rd_ch = '0;
        ack_en = 1'b0; ack_ch = '0; ovr_clr = 1'b0;
        @(negedge clk);
        run(2);
        rst = 1'b0;

        // Idle count and a low-time read
        run(10);
        check("idle_time", g_time, 64'd10);
        check("idle_pending", 64'(pending), 64'd0);
        do_rd(2'd0, 0);
        check("idle_rd_lo", 64'(rd_data), 64'd10);

        // Periodic channel 2
        do_wr(2'd2, 2, 32'd5);
        do_wr(2'd3, 2, 32'd20);
        do_en(2, 1'b1);
        run_until_lo(32'd20);
        step();
        check("ch2_pending", 64'(pending[2]), 64'd1);
        check("ch2_top_ch", 64'(top_ch), 64'd2);
        step();
        check("ch2_exc", 64'(exc), 64'd1);
        do_rd(2'd3, 2);
        check("ch2_next_fire", 64'(rd_data), 64'd25);
        do_ack(2);
        check("ch2_acked", 64'(pending[2]), 64'd0);
        run_until_lo(32'd25);
        step();
        check("ch2_refire", 64'(pending[2]), 64'd1);

        // Channels 1 and 3 fire together
        do_en(2, 1'b0);
        do_ack(2);
        tg = m_time[DW-1:0] + 32'd12;
        do_wr(2'd2, 1, 32'd100);
        do_wr(2'd2, 3, 32'd100);
        do_wr(2'd3, 1, tg);
        do_wr(2'd3, 3, tg);
        do_en(1, 1'b1);
        do_en(3, 1'b1);
        run_until_lo(tg);
        step();
        check("dual_top_ch", 64'(top_ch), 64'd1);
        step();
        check("dual_exc", 64'(exc), 64'd1);
        do_ack(1);
        check("dual_top_after_ack1", 64'(top_ch), 64'd3);
        do_ack(3);
        check("dual_top_valid_clear", 64'(top_valid), 64'd0);
        do_en(1, 1'b0);
        do_en(3, 1'b0);

        // One-shot channel 0, then overrun
        do_wr(2'd0, 0, 32'd0);
        do_wr(2'd2, 0, 32'd0);
        do_wr(2'd3, 0, 32'd7);
        do_en(0, 1'b1);
        run_until_lo(32'd7);
        step();
        check("oneshot_pending", 64'(pending[0]), 64'd1);
        do_wr(2'd0, 0, 32'd5);
        run_until_lo(32'd9);
        check("oneshot_no_refire", 64'(overrun[0]), 64'd0);
        do_en(0, 1'b1);
        do_wr(2'd3, 0, 32'd14);
        run_until_lo(32'd14);
        step();
        check("oneshot_overrun", 64'(overrun[0]), 64'd1);
        ovr_clr = 1'b1;
        do_ack(0);
        check("ovr_cleared", 64'(overrun), 64'd0);

        // Carry across the low/high boundary with a coherent read pair
        do_wr(2'd0, 0, 32'hFFFF_FFFD);
        do_wr(2'd1, 0, 32'd0);
        run_until_lo(32'hFFFF_FFFF);
        do_rd(2'd0, 0);
        check("carry_rd_lo", 64'(rd_data), 64'hFFFF_FFFF);
        check("carry_time", g_time, 64'h1_0000_0000);
        do_rd(2'd1, 0);
        check("carry_rd_hi", 64'(rd_data), 64'd0);

        // Out-of-range channel accesses
        do_wr(2'd2, 7, 32'd9);
        do_en(6, 1'b1);
        do_rd(2'd2, 6);
        check("oor_rd", 64'(rd_data), 64'd0);

        // Channel 4: ack+fire collision, then phase write at compare time
        do_wr(2'd2, 4, 32'd3);
        do_wr(2'd3, 4, m_time[DW-1:0] + 32'd4);
        do_en(4, 1'b1);
        run_until_lo(m_nf[4]);
        step();
        check("ch4_first_fire", 64'(pending[4]), 64'd1);
        run_until_lo(m_nf[4]);
        do_ack(4);
        check("ch4_ackfire_pend", 64'(pending[4]), 64'd1);
        check("ch4_ackfire_ovr", 64'(overrun[4]), 64'd0);
        run_until_lo(m_nf[4]);
        do_wr(2'd3, 4, m_nf[4] + 32'd20);
        check("ch4_phase_suppress", 64'(overrun[4]), 64'd0);
        run(3);

        // Mid-run reset
        rst = 1'b1;
        rd_en = 1'b1;
        step();
        rst = 1'b0;
        check("rst_time", g_time, 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_exc", 64'(exc), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) rand_cycle();

        mon_en = 1'b0;
        check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp2_tt_timer_unit.md
Name: cp2_tt_timer_unit

Overview:
- Parametrised global-time and time-trigger unit for the CP2 coprocessor.
- Holds a TIME_W-bit free-running global time and NUM_CH periodic or one-shot compare channels.
- Keeps per-channel pending and overrun flags, a fixed-priority top-channel encoder, and a one-cycle exception pulse when pending goes from empty to non-empty.
- Sits between the CP2 writeback/decode stages (register access) and the exception path toward the CPU.

Parameters:
- TIME_W, 64, global time width; must be greater than DATA_W and at most 2*DATA_W.
- DATA_W, 32, register and data-bus width; compare width.
- NUM_CH, 8, number of trigger channels (1..64).
- CH_AW, 3, channel index width; must satisfy 2^CH_AW >= NUM_CH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  write strobe.
- wr_kind  in  2  write target: 0 time_lo, 1 time_hi, 2 period[wr_ch], 3 phase[wr_ch].
- wr_ch  in  CH_AW  channel index for kinds 2/3.
- wr_data  in  DATA_W  write data.
- en_we  in  1  channel-enable write strobe.
- en_ch  in  CH_AW  channel for en_we.
- en_val  in  1  new enable value.
- rd_en  in  1  read request.
- rd_kind  in  2  read source: 0 time_lo, 1 time_hi (shadow), 2 period[rd_ch], 3 next_fire[rd_ch].
- rd_ch  in  CH_AW  channel index for reads.
- rd_valid  out  1  read data valid.
- rd_data  out  DATA_W  read data.
- ack_en  in  1  acknowledge strobe; clears pending[ack_ch].
- ack_ch  in  CH_AW  channel to acknowledge.
- ovr_clr  in  1  clears all overrun flags.
- g_time  out  TIME_W  current global time.
- pending  out  NUM_CH  pending flags.
- overrun  out  NUM_CH  sticky overrun flags.
- top_valid  out  1  at least one channel pending.
- top_ch  out  CH_AW  lowest-index pending channel.
- exc  out  1  one-cycle exception pulse.

Behaviour:
- Reset: g_time=0, all period/next_fire/shadow=0, enable=0, pending=0, overrun=0, rd_valid=0, rd_data=0, exc=0, top_valid=0, top_ch=0.
- Global time:
  - Each cycle g_time <= g_time+1, wrapping mod 2^TIME_W.
  - wr_en with kind 0 or 1 loads the addressed half (high half is the upper TIME_W-DATA_W bits, taking the low bits of wr_data). The other half holds and there is no increment that cycle.
- Channel fire:
  - Condition: enable[c] && g_time[DATA_W-1:0]==next_fire[c], using the pre-update g_time.
  - On fire: pending[c]<=1 and next_fire[c]<=next_fire[c]+period[c] (mod 2^DATA_W).
  - If period[c]==0 the channel is one-shot: enable[c]<=0 and next_fire is unchanged.
  - If pending[c] was already 1 and is not being acked in the same cycle, overrun[c]<=1.
- Phase write (kind 3): next_fire[wr_ch]<=wr_data.
  - Suppresses any fire of that channel in the same cycle.
  - Pending is unaffected.
- Period write (kind 2): takes effect from the next fire.
- en_we: enable[en_ch]<=en_val. Disabling a channel does not clear pending.
- Ack: ack_en clears pending[ack_ch].
  - Ack and fire on the same channel in the same cycle: pending stays 1, no overrun.
  - Ack of a non-pending channel has no effect.
- Time write and fire in the same cycle: the fire uses the old time and both take effect.
- ovr_clr clears all overrun flags; a fire in the same cycle that overruns still sets its bit (set wins).
- Out-of-range channel index (>= NUM_CH): writes, enables and acks are ignored; reads return 0.
- Read:
  - Registered, 1-cycle latency: rd_valid=1 the cycle after rd_en, otherwise 0.
  - Reading kind 0 returns g_time[DATA_W-1:0] and snapshots the upper bits into shadow in the same cycle.
  - Kind 1 returns the zero-extended shadow, so a lo-then-hi sequence gives a coherent TIME_W value.
  - Read data reflects state before any same-cycle write.
- top_valid/top_ch: combinational from the pending register; lowest index wins; top_ch=0 when none pending.
- exc: registered. exc=1 for exactly one cycle when pending_prev==0 and pending!=0, i.e. the cycle after the first pending bit appears. A new empty->non-empty transition re-arms it.

Decomposition:
- Shared package cp2_tt_pkg holds:
  - wr/rd kind encodings (TT_KIND_TLO=0, TT_KIND_THI=1, TT_KIND_PER=2, TT_KIND_PH=3);
  - default widths TT_TIME_W/TT_DATA_W;
  - the reset constants.
- One natural sub-module: cp2_tt_prio_enc, a parametrised lowest-index-first priority encoder (NUM_CH -> valid, CH_AW index).
- Per-channel compare/update logic stays in a generate loop.

Test Plan:
- Reset, then 10 cycles idle -> g_time==10, pending==0, exc never asserted, rd of kind 0 gives 10 (sampled).
- period[2]=5, phase[2]=20, enable ch2 -> pending[2] rises at g_time=20 (next_fire becomes 25), exc pulses one cycle later, top_ch=2; ack, then re-fires at g_time=25.
- Channels 1 and 3 fire in the same cycle -> top_ch=1, single exc pulse; ack ch1 -> top_ch=3; ack ch3 -> top_valid=0.
- period[0]=0 (one-shot), phase=7, enable -> fires once at g_time=7, enable[0]=0, no fire at 7+2^32; no ack, with ch0 re-enabled and phase=9 -> overrun[0]=1 at g_time=9.
- Write time_lo=0xFFFFFFFF, time_hi=0 -> next cycle g_time=0x1_0000_0000; read lo then hi across the carry -> coherent pair.
- Same-cycle ack+fire on ch4 -> pending[4] stays 1, overrun[4]=0; same-cycle phase write on ch4 at its compare time -> no fire; rst asserted mid-run -> all outputs at reset values next cycle.
